// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 4-digit 7-segment display, with a minimum dwell time
// and an owner lock. The grant and the display value are both registered.
module seg_display_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter logic [15:0] BLANK_VAL    = 16'h0000,
  localparam int unsigned OW          = (NREQ > 2) ? $clog2(NREQ) : 1,
  localparam int unsigned DW          = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_data,
  input  logic                 lock,
  output logic [NREQ-1:0]      grant,
  output logic [OW-1:0]        owner,
  output logic [15:0]          disp_num,
  output logic                 disp_valid
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES - 1);

  state_t          state, state_n;
  logic [OW-1:0]   owner_n, other_idx, cand;
  logic            other_found;
  logic [DW-1:0]   dwell, dwell_n;
  logic [NREQ-1:0] grant_n;

  // Search runs from the farthest candidate down to owner+1, so the nearest
  // requester after the owner is the last one written and wins.
  always_comb begin
    other_found = 1'b0;
    other_idx   = owner;
    cand        = owner;
    for (int unsigned k = NREQ - 1; k >= 1; k--) begin
      cand = OW'((32'(owner) + k) % NREQ);
      if (req[cand]) begin
        other_found = 1'b1;
        other_idx   = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    dwell_n = dwell;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = OWN;
          dwell_n = '0;
          owner_n = other_found ? other_idx : owner;
        end
      end
      OWN: begin
        if (!req[owner]) begin
          dwell_n = '0;
          if (other_found) owner_n = other_idx;
          else             state_n = IDLE;
        end else if (dwell == DWELL_MAX && !lock && other_found) begin
          owner_n = other_idx;
          dwell_n = '0;
        end else if (dwell != DWELL_MAX) begin
          dwell_n = dwell + DW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        dwell_n = '0;
      end
    endcase
  end

  always_comb begin
    grant_n          = '0;
    grant_n[owner_n] = (state_n == OWN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= OW'(NREQ - 1);
      dwell <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      dwell <= dwell_n;
    end
  end

  // Outputs are loaded from the post-edge owner, so the new owner's data appears on the same edge as its grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      disp_num   <= BLANK_VAL;
      disp_valid <= 1'b0;
    end else begin
      grant      <= grant_n;
      disp_valid <= (state_n == OWN);
      disp_num   <= (state_n == OWN) ? req_data[16*owner_n +: 16] : BLANK_VAL;
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed and randomized bench for seg_display_arbiter, checked against a
// cycle-count reference model of the ownership rules.
module tb_seg_display_arbiter;
  localparam int N = 4;
  localparam int D = 8;
  localparam logic [15:0] BLANK = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        lock;
  logic [3:0]  req;
  logic [15:0] data [4];
  logic [63:0] req_data;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic [15:0] disp_num;
  logic        disp_valid;

  int errors = 0;
  int checks = 0;

  bit m_act;
  int m_own;
  int m_start;
  int cyc = 0;

  always #5 clk = ~clk;

  assign req_data = {data[3], data[2], data[1], data[0]};

  seg_display_arbiter #(
    .NREQ(N),
    .DWELL_CYCLES(D),
    .BLANK_VAL(BLANK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .lock(lock),
    .grant(grant),
    .owner(owner),
    .disp_num(disp_num),
    .disp_valid(disp_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requester after 'from' (wrapping); 'from' itself only as a last resort.
  function automatic int rr_pick(int from, logic [3:0] r, bit include_from);
    for (int k = 1; k < N; k++) begin
      int i;
      i = (from + k) % N;
      if (r[i]) return i;
    end
    if (include_from && r[from]) return from;
    return -1;
  endfunction

  task automatic model_reset();
    m_act   = 1'b0;
    m_own   = N - 1;
    m_start = cyc;
  endtask

  task automatic model_edge();
    int other;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    other = rr_pick(m_own, req, 1'b0);
    if (!m_act) begin
      if (req != 4'b0) begin
        m_act   = 1'b1;
        m_own   = rr_pick(m_own, req, 1'b1);
        m_start = cyc;
      end
    end else if (!req[m_own]) begin
      if (other >= 0) begin
        m_own   = other;
        m_start = cyc;
      end else begin
        m_act = 1'b0;
      end
    end else if ((cyc - m_start) >= D && !lock && other >= 0) begin
      m_own   = other;
      m_start = cyc;
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0]  eg;
    logic [15:0] ed;
    eg = m_act ? 4'(1 << m_own) : 4'b0000;
    ed = m_act ? data[m_own] : BLANK;
    chk({tag, "_grant"}, 32'(grant), 32'(eg));
    chk({tag, "_owner"}, 32'(owner), 32'(m_own));
    chk({tag, "_disp"},  32'(disp_num), 32'(ed));
    chk({tag, "_valid"}, 32'(disp_valid), 32'(m_act));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step("rst");
    rst = 1'b0;
  endtask

  task automatic async_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    int g2;
    rst  = 1'b1;
    lock = 1'b0;
    req  = 4'b1111;
    for (int i = 0; i < N; i++) data[i] = 16'($urandom);
    model_reset();

    // Reset with every requester active, then first grant goes to requester 0
    step("reset");
    step("reset");
    chk("reset_grant_const", 32'(grant), 32'h0);
    rst = 1'b0;
    step("first");
    chk("first_grant_const", 32'(grant), 32'h1);
    req = 4'b0000;
    step("idle0");

    // Single requester held indefinitely; data change visible one cycle later
    data[1] = 16'h1234;
    req     = 4'b0010;
    step("single");
    chk("single_disp_const", 32'(disp_num), 32'h1234);
    repeat (50) step("single_hold");
    data[1] = 16'hABCD;
    step("single_data");
    chk("single_abcd_const", 32'(disp_num), 32'hABCD);
    req = 4'b0000;
    step("single_rel");

    // Rotation with requester 2 idle
    do_reset();
    req = 4'b1011;
    g2  = 0;
    step("rot");
    chk("rot_first_const", 32'(grant), 32'h1);
    for (int i = 0; i < 40; i++) begin
      step("rot");
      if (grant[2]) g2++;
    end
    chk("rot_no_req2", 32'(g2), 32'h0);

    // Lock extends ownership beyond the dwell time
    do_reset();
    req = 4'b0001;
    step("lock_own");
    req = 4'b0011;
    step("lock_c1");
    lock = 1'b1;
    repeat (18) step("lock_hold");
    chk("lock_held_const", 32'(grant), 32'h1);
    lock = 1'b0;
    step("lock_fall");
    chk("lock_switch_const", 32'(grant), 32'h2);
    req = 4'b0000;
    step("lock_rel");

    // Early release with another requester pending
    do_reset();
    req = 4'b0010;
    step("rel_own");
    req = 4'b1010;
    step("rel_c2");
    step("rel_c3");
    req = 4'b1000;
    step("rel_switch");
    chk("rel_switch_const", 32'(grant), 32'h8);
    repeat (3) step("rel_after");

    // Early release with nothing pending
    do_reset();
    req = 4'b0010;
    repeat (3) step("rel2_own");
    req = 4'b0000;
    step("rel2_idle");
    chk("rel2_disp_const", 32'(disp_num), 32'hFFFF);

    // Asynchronous reset while requester 2 owns the display
    do_reset();
    req = 4'b0100;
    step("async_own");
    step("async_own2");
    async_pulse("async_rst");
    chk("async_grant_const", 32'(grant), 32'h0);
    step("async_regrant");
    chk("async_regrant_const", 32'(grant), 32'h4);

    // Randomized traffic with occasional locks and asynchronous resets
    req = 4'($urandom_range(15));
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) req = 4'($urandom_range(15));
      lock = ($urandom_range(4) == 0);
      for (int j = 0; j < N; j++) data[j] = 16'($urandom);
      step("rand");
      if ($urandom_range(149) == 0) async_pulse("rand_async");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
